// File: rtl/aes_if_pkg.sv
// aes_if_pkg: shared state enum, bus address map and STATUS bit positions for aes_bus_interface
package aes_if_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [1:0] ADDR_MSG = 2'd0;
  localparam logic [1:0] ADDR_KEY = 2'd1;
  localparam logic [1:0] ADDR_CIPHER = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam int ST_MSG_VALID = 0;
  localparam int ST_KEY_VALID = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_DONE = 3;
  localparam int ST_ERR = 4;
  localparam int CTL_CLR_ERR = 4;
  localparam int CTL_ABORT = 5;
endpackage

// File: rtl/aes_bus_interface_if.sv
// aes_bus_interface_if: host bus controls (cs/rw/addr) plus crypto core side signals
// master: host/core side drives cs, rw, addr, crypte, core_done; slave: bridge drives message, key, start, busy
interface aes_bus_interface_if #(parameter int BLOCK_W = 128) ();
  logic cs;
  logic rw;
  logic [1:0] addr;
  logic [BLOCK_W-1:0] crypte;
  logic core_done;
  logic [BLOCK_W-1:0] message;
  logic [BLOCK_W-1:0] key;
  logic start;
  logic busy;
  modport master (output cs, rw, addr, crypte, core_done, input message, key, start, busy);
  modport slave (input cs, rw, addr, crypte, core_done, output message, key, start, busy);
endinterface

// File: rtl/aes_word_shreg.sv
// aes_word_shreg: block register with word shift-in at the LSBs, parallel load, and shift-out of the top word
// ports: clk, reset (async high), shift_en/din shift a word in (din = 0 shifts out), load_en/load_val parallel load, q block
module aes_word_shreg #(
  parameter int DATA_W = 32,
  parameter int BLOCK_W = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic [DATA_W-1:0] din,
  input  logic load_en,
  input  logic [BLOCK_W-1:0] load_val,
  output logic [BLOCK_W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (load_en) q <= load_val;
    else if (shift_en) q <= {q[BLOCK_W-DATA_W-1:0], din};
endmodule

// File: rtl/aes_bus_interface.sv
// aes_bus_interface: word-wide bus bridge that assembles message/key blocks, launches the core and drains ciphertext
// ports: clk, reset (async high), data (bidirectional bus word), bus (slave modport: cs/rw/addr, crypte/core_done, message/key/start/busy)
module aes_bus_interface import aes_if_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int BLOCK_W = 128
) (
  input  logic clk,
  input  logic reset,
  inout  wire  [DATA_W-1:0] data,
  aes_bus_interface_if.slave bus
);
  localparam int WORDS = BLOCK_W / DATA_W;
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
  state_t state;
  logic [CNT_W-1:0] msg_cnt, key_cnt, rd_cnt;
  logic msg_valid, key_valid, err, start, busy;
  logic [BLOCK_W-1:0] msg_q, key_q, out_q;
  logic wr, rd, idle, msg_wr, key_wr, wr_bad, cipher_rd, drain, abort, clr_err, launch, capture, drive;
  logic [DATA_W-1:0] status, rdata;
  always_comb begin
    wr = bus.cs & ~bus.rw;
    rd = bus.cs & bus.rw;
    idle = state == IDLE;
    msg_wr = wr & bus.addr == ADDR_MSG & idle & ~msg_valid;
    key_wr = wr & bus.addr == ADDR_KEY & idle;
    wr_bad = wr & ((bus.addr == ADDR_MSG & ~msg_wr) | (bus.addr == ADDR_KEY & ~idle));
    cipher_rd = rd & bus.addr == ADDR_CIPHER;
    drain = cipher_rd & state == DONE;
    abort = wr & bus.addr == ADDR_STATUS & data[CTL_ABORT] & idle;
    clr_err = wr & bus.addr == ADDR_STATUS & data[CTL_CLR_ERR];
    // an abort in the launch cycle wins, so no start escapes with cleared flags
    launch = idle & msg_valid & key_valid & ~abort;
    capture = state == BUSY & bus.core_done;
    status = '0;
    status[ST_MSG_VALID] = msg_valid;
    status[ST_KEY_VALID] = key_valid;
    status[ST_BUSY] = busy;
    status[ST_DONE] = state == DONE;
    status[ST_ERR] = err;
    rdata = bus.addr == ADDR_CIPHER ? (state == DONE ? out_q[BLOCK_W-1 -: DATA_W] : '0) : status;
    drive = rd & (bus.addr == ADDR_CIPHER | bus.addr == ADDR_STATUS);
  end
  assign data = drive ? rdata : 'z;
  assign bus.message = msg_q;
  assign bus.key = key_q;
  assign bus.start = start;
  assign bus.busy = busy;
  aes_word_shreg #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_msg (
    .clk(clk), .reset(reset), .shift_en(msg_wr), .din(data), .load_en(1'b0), .load_val('0), .q(msg_q));
  aes_word_shreg #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_key (
    .clk(clk), .reset(reset), .shift_en(key_wr), .din(data), .load_en(1'b0), .load_val('0), .q(key_q));
  aes_word_shreg #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_out (
    .clk(clk), .reset(reset), .shift_en(drain), .din('0), .load_en(capture), .load_val(bus.crypte), .q(out_q));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      msg_cnt <= '0;
      key_cnt <= '0;
      rd_cnt <= '0;
      msg_valid <= 1'b0;
      key_valid <= 1'b0;
      err <= 1'b0;
      start <= 1'b0;
      busy <= 1'b0;
    end else begin
      start <= launch;
      busy <= launch | (busy & ~capture);
      err <= wr_bad | (cipher_rd & state != DONE) | (err & ~clr_err);
      if (abort) begin
        msg_cnt <= '0;
        key_cnt <= '0;
        msg_valid <= 1'b0;
        key_valid <= 1'b0;
      end else begin
        if (msg_wr) msg_cnt <= msg_cnt == LAST ? '0 : msg_cnt + 1'b1;
        if (msg_wr && msg_cnt == LAST) msg_valid <= 1'b1;
        if (key_wr) key_cnt <= key_cnt == LAST ? '0 : key_cnt + 1'b1;
        if (key_wr && key_cnt == LAST) key_valid <= 1'b1;
        if (launch) msg_valid <= 1'b0;
      end
      if (launch) state <= BUSY;
      else if (capture) begin
        state <= DONE;
        rd_cnt <= '0;
      end else if (drain) begin
        rd_cnt <= rd_cnt == LAST ? '0 : rd_cnt + 1'b1;
        if (rd_cnt == LAST) state <= IDLE;
      end
    end
endmodule
